// File: rtl/hog_frame_ctrl_pkg.sv
// Shared definitions for the HOG frame controller: register map, field bit
// positions, FSM state encoding and the byte-strobe merge helper.
package hog_frame_ctrl_pkg;

    localparam int unsigned AxiDataWidth = 32;
    localparam int unsigned AxiAddrWidth = 5;
    localparam int unsigned RowsWidth    = 10;

    // Register word indices (byte address bits [4:2])
    localparam logic [2:0] RegCtrl   = 3'd0;
    localparam logic [2:0] RegStatus = 3'd1;
    localparam logic [2:0] RegBase   = 3'd2;
    localparam logic [2:0] RegRows   = 3'd3;
    localparam logic [2:0] RegStride = 3'd4;
    localparam logic [2:0] RegRowCnt = 3'd5;
    localparam logic [2:0] RegPerf   = 3'd6;

    localparam int unsigned CtrlStartBit  = 0;
    localparam int unsigned CtrlIrqEnBit  = 1;
    localparam int unsigned CtrlAbortBit  = 2;
    localparam int unsigned StatusBusyBit = 0;
    localparam int unsigned StatusDoneBit = 1;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StAdv,
        StDone
    } frame_state_e;

    // Replace only the bytes whose strobe bit is set
    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[i*8 +: 8] = strb[i] ? new_val[i*8 +: 8] : old_val[i*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/hog_frame_ctrl_axil.sv
// AXI4-Lite slave for the HOG frame controller: single-outstanding write and
// read handshakes plus the programmable register storage. START/ABORT leave
// as combinational pulses so the FSM reacts on the same edge as the write.
module hog_frame_ctrl_axil
    import hog_frame_ctrl_pkg::*;
#(
    parameter int unsigned DataWidth = AxiDataWidth,
    parameter int unsigned AddrWidth = AxiAddrWidth
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [AddrWidth-1:0]   s_axi_awaddr,
    input  logic                   s_axi_awvalid,
    output logic                   s_axi_awready,
    input  logic [DataWidth-1:0]   s_axi_wdata,
    input  logic [DataWidth/8-1:0] s_axi_wstrb,
    input  logic                   s_axi_wvalid,
    output logic                   s_axi_wready,
    output logic [1:0]             s_axi_bresp,
    output logic                   s_axi_bvalid,
    input  logic                   s_axi_bready,
    input  logic [AddrWidth-1:0]   s_axi_araddr,
    input  logic                   s_axi_arvalid,
    output logic                   s_axi_arready,
    output logic [DataWidth-1:0]   s_axi_rdata,
    output logic [1:0]             s_axi_rresp,
    output logic                   s_axi_rvalid,
    input  logic                   s_axi_rready,
    output logic                   start,
    output logic                   abort,
    output logic                   irq_en,
    output logic                   done,
    output logic [31:0]            base,
    output logic [31:0]            stride,
    output logic [RowsWidth-1:0]   rows,
    input  logic                   busy,
    input  logic                   done_set,
    input  logic [RowsWidth-1:0]   row_cnt,
    input  logic [31:0]            perf_cnt
);

    logic                 irq_en_q, done_q, bvalid_q, rvalid_q;
    logic [31:0]          base_q, stride_q, rdata_q, rd_mux;
    logic [RowsWidth-1:0] rows_q;
    logic                 wr_en, rd_en, done_clr;
    logic [2:0]           wr_idx, rd_idx;
    logic                 unused_addr;

    assign wr_idx      = s_axi_awaddr[4:2];
    assign rd_idx      = s_axi_araddr[4:2];
    assign unused_addr = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    // Handshake qualification and write-side pulse decode
    always_comb begin
        wr_en    = s_axi_awvalid & s_axi_wvalid & ~bvalid_q & ~rst;
        rd_en    = s_axi_arvalid & ~rvalid_q & ~rst;
        start    = wr_en & (wr_idx == RegCtrl) & s_axi_wstrb[0] & s_axi_wdata[CtrlStartBit];
        abort    = wr_en & (wr_idx == RegCtrl) & s_axi_wstrb[0] & s_axi_wdata[CtrlAbortBit];
        done_clr = wr_en & (wr_idx == RegStatus) & s_axi_wstrb[0] & s_axi_wdata[StatusDoneBit];
    end

    // Register storage, sticky DONE and the write response channel
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_en_q <= 1'b0;
            done_q   <= 1'b0;
            base_q   <= '0;
            stride_q <= '0;
            rows_q   <= '0;
            bvalid_q <= 1'b0;
        end else begin
            if (wr_en) begin
                case (wr_idx)
                    RegCtrl:   if (s_axi_wstrb[0]) irq_en_q <= s_axi_wdata[CtrlIrqEnBit];
                    RegBase:   base_q   <= apply_wstrb(base_q, s_axi_wdata, s_axi_wstrb);
                    RegStride: stride_q <= apply_wstrb(stride_q, s_axi_wdata, s_axi_wstrb);
                    RegRows:   rows_q   <= RowsWidth'(apply_wstrb(32'(rows_q), s_axi_wdata,
                                                              s_axi_wstrb));
                    default:   ;
                endcase
            end
            // A completing frame wins over a clear landing on the same edge
            if (done_set) begin
                done_q <= 1'b1;
            end else if (done_clr) begin
                done_q <= 1'b0;
            end
            if (bvalid_q && s_axi_bready) begin
                bvalid_q <= 1'b0;
            end else if (wr_en) begin
                bvalid_q <= 1'b1;
            end
        end
    end

    // Read data multiplexer; unmapped words return zero
    always_comb begin
        rd_mux = '0;
        case (rd_idx)
            RegCtrl:   rd_mux[CtrlIrqEnBit] = irq_en_q;
            RegStatus: begin
                rd_mux[StatusBusyBit] = busy;
                rd_mux[StatusDoneBit] = done_q;
            end
            RegBase:   rd_mux = base_q;
            RegRows:   rd_mux[RowsWidth-1:0] = rows_q;
            RegStride: rd_mux = stride_q;
            RegRowCnt: rd_mux[RowsWidth-1:0] = row_cnt;
            RegPerf:   rd_mux = perf_cnt;
            default:   rd_mux = '0;
        endcase
    end

    // Registered read response held until the master takes it
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else if (rd_en) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_mux;
        end else if (rvalid_q && s_axi_rready) begin
            rvalid_q <= 1'b0;
        end
    end

    assign s_axi_awready = wr_en;
    assign s_axi_wready  = wr_en;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = 2'b00;
    assign s_axi_arready = rd_en;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = 2'b00;

    assign irq_en = irq_en_q;
    assign done   = done_q;
    assign base   = base_q;
    assign stride = stride_q;
    assign rows   = rows_q;

endmodule

// File: rtl/hog_frame_ctrl.sv
// HOG frame controller top: walks an image frame row by row, handing each
// row's byte address to the HP transfer engine and waiting for its ack.
// Optional feature: define HOG_FRAME_CTRL_PERF_EN to add the PERF busy-cycle
// counter; otherwise PERF reads zero.
module hog_frame_ctrl
    import hog_frame_ctrl_pkg::*;
#(
    parameter int C_S_AXI_GP_DATA_WIDTH = 32,
    parameter int C_S_AXI_GP_ADDR_WIDTH = 5
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [C_S_AXI_GP_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                               s_axi_awvalid,
    output logic                               s_axi_awready,
    input  logic [C_S_AXI_GP_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_S_AXI_GP_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                               s_axi_wvalid,
    output logic                               s_axi_wready,
    output logic [1:0]                         s_axi_bresp,
    output logic                               s_axi_bvalid,
    input  logic                               s_axi_bready,
    input  logic [C_S_AXI_GP_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic                               s_axi_arvalid,
    output logic                               s_axi_arready,
    output logic [C_S_AXI_GP_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                         s_axi_rresp,
    output logic                               s_axi_rvalid,
    input  logic                               s_axi_rready,
    output logic                               row_req,
    output logic [31:0]                        row_base,
    input  logic                               row_ack,
    output logic                               irq
);

    frame_state_e         state_q, state_d;
    logic                 start, abort, irq_en, done, busy, done_set;
    logic [31:0]          base, stride, perf_cnt;
    logic [RowsWidth-1:0] rows;
    logic [RowsWidth-1:0] row_idx_q, rows_lat_q;
    logic [31:0]          row_base_q, stride_lat_q;

    hog_frame_ctrl_axil #(
        .DataWidth(C_S_AXI_GP_DATA_WIDTH),
        .AddrWidth(C_S_AXI_GP_ADDR_WIDTH)
    ) u_axil (
        .clk          (clk),
        .rst          (rst),
        .s_axi_awaddr (s_axi_awaddr),
        .s_axi_awvalid(s_axi_awvalid),
        .s_axi_awready(s_axi_awready),
        .s_axi_wdata  (s_axi_wdata),
        .s_axi_wstrb  (s_axi_wstrb),
        .s_axi_wvalid (s_axi_wvalid),
        .s_axi_wready (s_axi_wready),
        .s_axi_bresp  (s_axi_bresp),
        .s_axi_bvalid (s_axi_bvalid),
        .s_axi_bready (s_axi_bready),
        .s_axi_araddr (s_axi_araddr),
        .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready),
        .s_axi_rdata  (s_axi_rdata),
        .s_axi_rresp  (s_axi_rresp),
        .s_axi_rvalid (s_axi_rvalid),
        .s_axi_rready (s_axi_rready),
        .start        (start),
        .abort        (abort),
        .irq_en       (irq_en),
        .done         (done),
        .base         (base),
        .stride       (stride),
        .rows         (rows),
        .busy         (busy),
        .done_set     (done_set),
        .row_cnt      (row_idx_q),
        .perf_cnt     (perf_cnt)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; ABORT overrides everything once a frame is running
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = (rows == '0) ? StDone : StReq;
                end
            end
            StReq: begin
                if (row_ack) begin
                    state_d = (row_idx_q == rows_lat_q - RowsWidth'(1)) ? StDone : StAdv;
                end
            end
            StAdv:   state_d = StReq;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (abort && (state_q != StIdle)) begin
            state_d = StIdle;
        end
    end

    // FSM outputs
    always_comb begin
        busy     = (state_q != StIdle);
        row_req  = (state_q == StReq);
        done_set = (state_q == StDone) & ~abort;
    end

    // Frame datapath: parameters are latched at start so mid-frame register
    // writes only affect the next frame
    always_ff @(posedge clk) begin
        if (rst) begin
            row_idx_q    <= '0;
            row_base_q   <= '0;
            rows_lat_q   <= '0;
            stride_lat_q <= '0;
        end else if ((state_q == StIdle) && start) begin
            row_idx_q    <= '0;
            row_base_q   <= base;
            rows_lat_q   <= rows;
            stride_lat_q <= stride;
        end else if ((state_q == StAdv) && !abort) begin
            row_idx_q  <= row_idx_q + RowsWidth'(1);
            row_base_q <= row_base_q + stride_lat_q;
        end
    end

`ifdef HOG_FRAME_CTRL_PERF_EN
    logic [31:0] perf_q;

    // Busy-cycle counter, restarted by each accepted START, saturating
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_q <= '0;
        end else if ((state_q == StIdle) && start) begin
            perf_q <= '0;
        end else if (busy && (perf_q != '1)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_cnt = perf_q;
`else
    assign perf_cnt = '0;
`endif

    assign row_base = row_base_q;
    assign irq      = done & irq_en;

endmodule

// File: tb/tb_hog_frame_ctrl.sv
// Self-checking bench for hog_frame_ctrl: register table, directed frame
// sequences and randomized frames against an arithmetic reference model.
`timescale 1ns/1ps
module tb_hog_frame_ctrl;

    localparam logic [4:0] A_CTRL   = 5'h00;
    localparam logic [4:0] A_STATUS = 5'h04;
    localparam logic [4:0] A_BASE   = 5'h08;
    localparam logic [4:0] A_ROWS   = 5'h0C;
    localparam logic [4:0] A_STRIDE = 5'h10;
    localparam logic [4:0] A_ROWCNT = 5'h14;
    localparam logic [4:0] A_PERF   = 5'h18;
    localparam logic [4:0] A_UNMAP  = 5'h1C;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  s_axi_awaddr = '0;
    logic        s_axi_awvalid = 1'b0;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata = '0;
    logic [3:0]  s_axi_wstrb = '0;
    logic        s_axi_wvalid = 1'b0;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready = 1'b0;
    logic [4:0]  s_axi_araddr = '0;
    logic        s_axi_arvalid = 1'b0;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready = 1'b0;
    logic        row_req;
    logic [31:0] row_base;
    logic        row_ack;
    logic        irq;

    hog_frame_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .s_axi_awaddr (s_axi_awaddr),
        .s_axi_awvalid(s_axi_awvalid),
        .s_axi_awready(s_axi_awready),
        .s_axi_wdata  (s_axi_wdata),
        .s_axi_wstrb  (s_axi_wstrb),
        .s_axi_wvalid (s_axi_wvalid),
        .s_axi_wready (s_axi_wready),
        .s_axi_bresp  (s_axi_bresp),
        .s_axi_bvalid (s_axi_bvalid),
        .s_axi_bready (s_axi_bready),
        .s_axi_araddr (s_axi_araddr),
        .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready),
        .s_axi_rdata  (s_axi_rdata),
        .s_axi_rresp  (s_axi_rresp),
        .s_axi_rvalid (s_axi_rvalid),
        .s_axi_rready (s_axi_rready),
        .row_req      (row_req),
        .row_base     (row_base),
        .row_ack      (row_ack),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Transfer-engine stand-in state
    bit          auto_en = 1'b0;
    bit          manual_ack = 1'b0;
    int          ack_delay = 0;
    int          rise_cnt = 0;
    logic [31:0] bases[$];
    logic        req_after_wr, irq_after_wr;

    typedef struct {
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [4:0]  raddr;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Acks each row ack_delay cycles after row_req rises; logs every row_base
    initial begin
        bit req_prev;
        int wait_cnt;
        req_prev = 1'b0;
        wait_cnt = 0;
        row_ack  = 1'b0;
        forever begin
            @(negedge clk);
            row_ack = manual_ack;
            if (row_req && !req_prev) begin
                rise_cnt++;
                bases.push_back(row_base);
                wait_cnt = 0;
            end
            if (row_req && auto_en) begin
                if (wait_cnt == ack_delay) row_ack = 1'b1;
                wait_cnt++;
            end
            req_prev = row_req;
        end
    end

    task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        int n;
        s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_bready = 1'b1;
        #1;
        n = 0;
        while (!(s_axi_awready && s_axi_wready) && n < 50) begin
            @(negedge clk); #1; n++;
        end
        check("write_accept", n < 50, 1);
        @(negedge clk);
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        req_after_wr = row_req;
        irq_after_wr = irq;
        n = 0;
        while (!s_axi_bvalid && n < 50) begin
            @(negedge clk); n++;
        end
        check("bvalid_seen", n < 50, 1);
        if (s_axi_bresp !== 2'b00) check("bresp", s_axi_bresp, 0);
        @(negedge clk);
    endtask

    task automatic axi_read(input logic [4:0] a, output logic [31:0] d);
        int n;
        s_axi_araddr = a; s_axi_arvalid = 1'b1; s_axi_rready = 1'b1;
        #1;
        n = 0;
        while (!s_axi_arready && n < 50) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 50) check("read_accept", n < 50, 1);
        @(negedge clk);
        s_axi_arvalid = 1'b0;
        n = 0;
        while (!s_axi_rvalid && n < 50) begin
            @(negedge clk); n++;
        end
        if (n >= 50) check("rvalid_seen", n < 50, 1);
        d = s_axi_rdata;
        if (s_axi_rresp !== 2'b00) check("rresp", s_axi_rresp, 0);
        @(negedge clk);
    endtask

    task automatic wait_done(input string name);
        logic [31:0] d;
        int n;
        d = '0;
        n = 0;
        while (!d[1] && n < 300) begin
            axi_read(A_STATUS, d);
            n++;
        end
        check({name, "_done"}, d[1], 1);
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] s);
        logic [31:0] m;
        m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (old_v & ~m) | (new_v & m);
    endfunction

    initial begin
        #900_000;
        $display("FAIL watchdog: got time limit reached, required self-termination");
        $fatal(1);
    end

    initial begin
        logic [31:0] d, m_base, m_stride, base0, stride0, exp_perf;
        logic [9:0]  m_rows;
        bit          ok;
        int          n;

        vecs[0]  = '{A_BASE,   32'h1234_5678, 4'hF, A_BASE,   32'h1234_5678};
        vecs[1]  = '{A_BASE,   32'hAABB_CCDD, 4'h5, A_BASE,   32'h12BB_56DD};
        vecs[2]  = '{A_STRIDE, 32'hFFFF_FFFF, 4'hF, A_STRIDE, 32'hFFFF_FFFF};
        vecs[3]  = '{A_STRIDE, 32'h0000_0000, 4'h8, A_STRIDE, 32'h00FF_FFFF};
        vecs[4]  = '{A_ROWS,   32'hFFFF_FFFF, 4'hF, A_ROWS,   32'h0000_03FF};
        vecs[5]  = '{A_ROWS,   32'h0000_0155, 4'h1, A_ROWS,   32'h0000_0355};
        vecs[6]  = '{A_ROWS,   32'h0000_0000, 4'h2, A_ROWS,   32'h0000_0055};
        vecs[7]  = '{A_CTRL,   32'h0000_0002, 4'hF, A_CTRL,   32'h0000_0002};
        vecs[8]  = '{A_CTRL,   32'h0000_0000, 4'h0, A_CTRL,   32'h0000_0002};
        vecs[9]  = '{A_CTRL,   32'h0000_0000, 4'hF, A_CTRL,   32'h0000_0000};
        vecs[10] = '{A_UNMAP,  32'hDEAD_BEEF, 4'hF, A_UNMAP,  32'h0000_0000};
        vecs[11] = '{A_ROWCNT, 32'h0000_FFFF, 4'hF, A_ROWCNT, 32'h0000_0000};
        vecs[12] = '{A_STATUS, 32'h0000_0002, 4'hF, A_STATUS, 32'h0000_0000};
        vecs[13] = '{A_PERF,   32'h1234_5678, 4'hF, A_PERF,   32'h0000_0000};
        vecs[14] = '{A_ROWS,   32'h0000_0000, 4'hF, A_ROWS,   32'h0000_0000};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_handshake", {s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready,
                                s_axi_rvalid, row_req, irq, s_axi_bresp, s_axi_rresp}, 0);
        check("rst_rdata", s_axi_rdata, 0);
        check("rst_row_base", row_base, 0);
        rst = 1'b0;
        @(negedge clk);

        // Register table
        for (int i = 0; i < 15; i++) begin
            axi_write(vecs[i].waddr, vecs[i].wdata, vecs[i].wstrb);
            axi_read(vecs[i].raddr, d);
            check($sformatf("vec%0d", i), d, vecs[i].exp);
        end

        // Three-row frame, ack 5 cycles after each request
        axi_write(A_BASE, 32'h1000_0000, 4'hF);
        axi_write(A_STRIDE, 32'h0000_0200, 4'hF);
        axi_write(A_ROWS, 32'd3, 4'hF);
        rise_cnt = 0; bases.delete(); ack_delay = 5; auto_en = 1'b1;
        axi_write(A_CTRL, 32'h1, 4'hF);
        wait_done("frame3");
        check("frame3_rises", rise_cnt, 3);
        for (int i = 0; i < 3; i++) begin
            d = (i < bases.size()) ? bases[i] : 32'hXXXX_XXXX;
            check($sformatf("frame3_base%0d", i), d, 32'h1000_0000 + 32'(i) * 32'h200);
        end
        axi_read(A_STATUS, d);
        check("frame3_status", d, 32'h2);
        axi_read(A_ROWCNT, d);
        check("frame3_rowcnt", d, 2);

        // Empty frame goes straight to DONE
        axi_write(A_STATUS, 32'h2, 4'hF);
        axi_write(A_ROWS, 32'd0, 4'hF);
        rise_cnt = 0;
        axi_write(A_CTRL, 32'h1, 4'hF);
        check("rows0_no_req_wr", req_after_wr, 0);
        @(negedge clk);
        axi_read(A_STATUS, d);
        check("rows0_status", d, 32'h2);
        check("rows0_rises", rise_cnt, 0);
`ifdef HOG_FRAME_CTRL_PERF_EN
        exp_perf = 32'd1;
`else
        exp_perf = 32'd0;
`endif
        axi_read(A_PERF, d);
        check("rows0_perf", d, exp_perf);

        // Interrupt on a one-row frame, then cleared by writing DONE
        axi_write(A_STATUS, 32'h2, 4'hF);
        axi_write(A_ROWS, 32'd1, 4'hF);
        ack_delay = 2; auto_en = 1'b1;
        axi_write(A_CTRL, 32'h3, 4'hF);
        check("irq_low_while_busy", irq, 0);
        n = 0;
        while (!irq && n < 50) begin
            @(negedge clk); n++;
        end
        check("irq_rise", irq, 1);
        axi_read(A_STATUS, d);
        check("irq_status_done", d, 32'h2);
        axi_write(A_STATUS, 32'h2, 4'hF);
        check("irq_clear_next", irq_after_wr, 0);
        check("irq_clear", irq, 0);

        // Abort during the second row of a four-row frame
        axi_write(A_CTRL, 32'h0, 4'hF);
        axi_write(A_BASE, 32'h0000_4000, 4'hF);
        axi_write(A_STRIDE, 32'h0000_0040, 4'hF);
        axi_write(A_ROWS, 32'd4, 4'hF);
        rise_cnt = 0; bases.delete(); ack_delay = 3; auto_en = 1'b1;
        axi_write(A_CTRL, 32'h1, 4'hF);
        n = 0;
        while (rise_cnt < 2 && n < 100) begin
            @(negedge clk); n++;
        end
        auto_en = 1'b0;
        check("abort_second_row", rise_cnt, 2);
        check("abort_req_before", row_req, 1);
        axi_write(A_CTRL, 32'h4, 4'hF);
        check("abort_req_next", req_after_wr, 0);
        axi_read(A_STATUS, d);
        check("abort_status", d, 32'h0);
        manual_ack = 1'b1;
        repeat (3) @(negedge clk);
        manual_ack = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_late_ack_req", row_req, 0);
        check("abort_late_ack_rises", rise_cnt, 2);
        axi_read(A_STATUS, d);
        check("abort_late_ack_status", d, 32'h0);
        axi_read(A_ROWCNT, d);
        check("abort_rowcnt", d, 1);

        // Row address wraps modulo 2^32
        axi_write(A_BASE, 32'hFFFF_FF00, 4'hF);
        axi_write(A_STRIDE, 32'h0000_0100, 4'hF);
        axi_write(A_ROWS, 32'd2, 4'hF);
        rise_cnt = 0; bases.delete(); ack_delay = 1; auto_en = 1'b1;
        axi_write(A_CTRL, 32'h1, 4'hF);
        wait_done("wrap");
        check("wrap_rises", rise_cnt, 2);
        d = (bases.size() > 1) ? bases[1] : 32'hXXXX_XXXX;
        check("wrap_base1", d, 32'h0000_0000);

        // Write response back-pressure
        s_axi_awaddr = A_BASE; s_axi_wdata = 32'h1111_1111; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_bready = 1'b0;
        #1;
        check("bp_first_accept", s_axi_awready, 1);
        @(negedge clk);
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        ok = 1'b1;
        repeat (10) begin
            if (!s_axi_bvalid) ok = 1'b0;
            @(negedge clk);
        end
        check("bp_bvalid_held", ok, 1);
        s_axi_wdata = 32'h2222_2222; s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        #1;
        check("bp_aw_blocked", {s_axi_awready, s_axi_wready}, 0);
        @(negedge clk);
        axi_read(A_BASE, d);
        check("bp_base_unchanged", d, 32'h1111_1111);
        #1;
        check("bp_aw_still_blocked", s_axi_awready, 0);
        @(negedge clk);
        s_axi_bready = 1'b1;
        @(negedge clk);
        #1;
        check("bp_aw_after_bready", s_axi_awready, 1);
        @(negedge clk);
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        @(negedge clk);
        axi_read(A_BASE, d);
        check("bp_base_updated", d, 32'h2222_2222);

        // Random register writes with random strobes
        axi_read(A_BASE, m_base);
        axi_read(A_STRIDE, m_stride);
        axi_read(A_ROWS, d);
        m_rows = d[9:0];
        for (int i = 0; i < 20; i++) begin
            logic [4:0]  a;
            logic [31:0] wd, exp;
            logic [3:0]  s;
            case ($urandom_range(0, 3))
                0:       a = A_BASE;
                1:       a = A_STRIDE;
                2:       a = A_ROWS;
                default: a = A_UNMAP;
            endcase
            wd = $urandom;
            s  = 4'($urandom_range(0, 15));
            axi_write(a, wd, s);
            if (a == A_BASE) m_base = merge(m_base, wd, s);
            if (a == A_STRIDE) m_stride = merge(m_stride, wd, s);
            if (a == A_ROWS) m_rows = merge({22'b0, m_rows}, wd, s) % 1024;
            exp = (a == A_BASE) ? m_base : (a == A_STRIDE) ? m_stride :
                  (a == A_ROWS) ? {22'b0, m_rows} : 32'h0;
            axi_read(a, d);
            check($sformatf("rand_reg%0d", i), d, exp);
        end

        // Random frames, some disturbed by writes while busy
        for (int f = 0; f < 20; f++) begin
            int  rows;
            bit  ien, disturb;
            rows    = $urandom_range(0, 6);
            ack_delay = $urandom_range(0, 3);
            ien     = 1'($urandom_range(0, 1));
            disturb = (rows >= 3) && (ack_delay >= 2);
            base0   = $urandom;
            stride0 = $urandom;
            axi_write(A_STATUS, 32'h2, 4'hF);
            axi_write(A_BASE, base0, 4'hF);
            axi_write(A_STRIDE, stride0, 4'hF);
            axi_write(A_ROWS, 32'(rows), 4'hF);
            m_base = base0;
            rise_cnt = 0; bases.delete(); auto_en = 1'b1;
            axi_write(A_CTRL, {30'b0, ien, 1'b1}, 4'hF);
            if (disturb) begin
                m_base = $urandom;
                axi_write(A_BASE, m_base, 4'hF);
                axi_write(A_CTRL, {30'b0, ien, 1'b1}, 4'hF);
            end
            wait_done($sformatf("rand_frame%0d", f));
            check($sformatf("rand_frame%0d_rises", f), rise_cnt, rows);
            for (int i = 0; i < rows; i++) begin
                d = (i < bases.size()) ? bases[i] : 32'hXXXX_XXXX;
                check($sformatf("rand_frame%0d_base%0d", f, i), d, base0 + 32'(i) * stride0);
            end
            check($sformatf("rand_frame%0d_irq", f), irq, ien);
            axi_read(A_ROWCNT, d);
            check($sformatf("rand_frame%0d_rowcnt", f), d, (rows == 0) ? 0 : rows - 1);
            if (disturb) begin
                axi_read(A_BASE, d);
                check($sformatf("rand_frame%0d_newbase", f), d, m_base);
            end
        end

        // Reset mid-frame with a write response outstanding
        axi_write(A_STATUS, 32'h2, 4'hF);
        axi_write(A_ROWS, 32'd3, 4'hF);
        rise_cnt = 0; ack_delay = 4; auto_en = 1'b1;
        axi_write(A_CTRL, 32'h3, 4'hF);
        n = 0;
        while (rise_cnt < 1 && n < 50) begin
            @(negedge clk); n++;
        end
        auto_en = 1'b0;
        s_axi_awaddr = A_STRIDE; s_axi_wdata = 32'h5; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_bready = 1'b0;
        @(negedge clk);
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        check("rstmid_bvalid_pending", s_axi_bvalid, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rstmid_outputs", {s_axi_bvalid, row_req, irq}, 0);
        @(negedge clk);
        s_axi_bready = 1'b1;
        axi_read(A_STATUS, d);
        check("rstmid_status", d, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hog_frame_ctrl.md
HOG_FRAME_CTRL -- requirements
Module: hog_frame_ctrl

Interface
REQ-001 C_S_AXI_GP_DATA_WIDTH, 32, AXI4-Lite GP data width; only 32 is supported.
REQ-002 C_S_AXI_GP_ADDR_WIDTH, 5, AXI4-Lite GP byte address width.
REQ-003 clk  in  1  single block clock; all logic rising-edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 s_axi_awaddr  in  5  write address.
REQ-006 s_axi_awvalid  in  1  write address valid.
REQ-007 s_axi_awready  out  1  write address ready.
REQ-008 s_axi_wdata  in  32  write data.
REQ-009 s_axi_wstrb  in  4  byte strobes; a byte is written only when its strobe bit is 1.
REQ-010 s_axi_wvalid / s_axi_wready  in / out  1  write data handshake.
REQ-011 s_axi_bresp / s_axi_bvalid / s_axi_bready  out / out / in  2 / 1 / 1  write response.
REQ-012 s_axi_araddr / s_axi_arvalid / s_axi_arready  in / in / out  5 / 1 / 1  read address.
REQ-013 s_axi_rdata / s_axi_rresp / s_axi_rvalid / s_axi_rready  out / out / out / in  32 / 2 / 1 / 1  read data.
REQ-014 row_req  out  1  request to the HP transfer engine to move one image row.
REQ-015 row_base  out  32  byte address of the requested row; stable while row_req=1.
REQ-016 row_ack  in  1  one-cycle pulse: the requested row is complete.
REQ-017 irq  out  1  level interrupt, equal to STATUS.DONE & CTRL.IRQ_EN.

Function
REQ-018 Register map, decoded on addr[4:2]: 0x00 CTRL; 0x04 STATUS; 0x08 BASE; 0x0C ROWS; 0x10 STRIDE; 0x14 ROW_CNT (read-only); 0x18 PERF.
REQ-019 Unmapped addresses read 0; writes to them are dropped; bresp and rresp are always OKAY (2'b00).
REQ-020 CTRL fields: bit0 START (write-1 pulse, reads 0); bit1 IRQ_EN (read/write); bit2 ABORT (write-1 pulse, reads 0).
REQ-021 STATUS fields: bit0 BUSY (read-only); bit1 DONE (sticky; write-1 clears it).
REQ-022 Register widths: ROWS is bits[9:0] only, upper bits read 0; BASE and STRIDE are full 32-bit.
REQ-023 Write channel: awready and wready are asserted together for one cycle when awvalid, wvalid and !bvalid are all high; the register updates on that edge.
REQ-024 Write response: bvalid asserts the next cycle and holds until bready is high.
REQ-025 Read channel: arready pulses one cycle when arvalid & !rvalid; rdata and rvalid are registered the next cycle; rvalid holds until rready.
REQ-026 FSM states: IDLE, REQ, ADV, DONE; BUSY = (state != IDLE).
REQ-027 IDLE -> REQ on START with ROWS != 0: row index := 0 and row_base := BASE; START with ROWS == 0 goes to DONE directly, with no row_req.
REQ-028 REQ: row_req = 1 until row_ack is seen; on row_ack, go to DONE if index == ROWS-1, otherwise go to ADV.
REQ-029 ADV lasts one cycle with row_req = 0: index += 1 and row_base += STRIDE (modulo 2^32, wraps silently); then back to REQ.
REQ-030 DONE lasts one cycle: sets STATUS.DONE, then returns to IDLE.
REQ-031 START while BUSY is ignored; writes to BASE, ROWS and STRIDE while BUSY update the registers but do not affect the running frame, whose values were latched at start.
REQ-032 ABORT while BUSY forces IDLE on the next edge and drops row_req; DONE is not set; ABORT in IDLE has no effect.
REQ-033 row_ack outside REQ is ignored; ROW_CNT reads the current row index.
REQ-034 Simultaneous START and DONE-clear write in IDLE: both take effect.

Reset
REQ-035 On rst all registers, the FSM (IDLE) and the counters go to 0; every output is 0 (row_req, row_base, irq, all ready/valid signals, bresp, rresp, rdata).
REQ-036 rst mid-frame aborts the frame without setting DONE; any pending AXI response is discarded.

Configuration
REQ-037 With HOG_FRAME_CTRL_PERF_EN defined: PERF is a 32-bit cycle counter, cleared on an accepted START, incrementing every cycle while BUSY, saturating at 0xFFFFFFFF.
REQ-038 Without HOG_FRAME_CTRL_PERF_EN: PERF reads 0 and no counter logic is present.

Structure
REQ-039 Package hog_frame_ctrl_pkg holds the register offsets, CTRL/STATUS bit positions, the FSM state enum and the ROWS width (10).
REQ-040 The AXI4-Lite handshake and register storage live in one sub-module, hog_frame_ctrl_axil; the FSM lives in the top level.

Verification
REQ-041 Write BASE=0x1000_0000, STRIDE=0x200, ROWS=3, then START; ack each request after 5 cycles -> row_base sequence 0x1000_0000, 0x1000_0200, 0x1000_0400; DONE=1; exactly 3 row_req rising edges.
REQ-042 ROWS=0, START -> no row_req; STATUS reads 0x2 two cycles after the write response.
REQ-043 IRQ_EN=1 with a 1-row frame -> irq rises with DONE; write STATUS=0x2 -> irq=0 next cycle.
REQ-044 ABORT during the 2nd row of a 4-row frame -> row_req=0 next cycle; STATUS=0x0; a later row_ack is ignored.
REQ-045 BASE=0xFFFF_FF00, STRIDE=0x100, ROWS=2 -> second row_base=0x0000_0000 (wrap).
REQ-046 Hold bready=0 for 10 cycles after a write -> bvalid stays high and the next AW/W is not accepted until bready.
